apb_master: RTL

- APB requester that drives the bus of the apb_slave and sits directly upstream of it.
- Accepts simple read/write commands on a valid/ready interface and buffers them in a small FIFO.
- Executes each command as one APB SETUP/ACCESS transfer, honouring slave wait states.
- Returns read data and error status on a valid/ready response interface.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_cmd_fifo.sv | 48 ++++
 rtl/apb_master.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM state encoding and default bus widths.
// Used by apb_master and apb_slave.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB to tell full from empty.
module apb_cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wrPtr_d = wrPtr_q + {{AW{1'b0}}, i_push};
        rdPtr_d = rdPtr_q + {{AW{1'b0}}, i_pop};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_q[wrPtr_q[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = mem_q[rdPtr_q[AW-1:0]];
    assign o_empty = (wrPtr_q == rdPtr_q);
    assign o_full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

endmodule

// File: rtl/apb_master.sv
// APB requester: buffers commands in a FIFO and runs each as one SETUP/ACCESS transfer.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that wait too long for PREADY.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_write,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PSELx,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              o_busy
);

    localparam int CMD_W = 1 + ADDR_W + DATA_W;

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rspValid_q, rspValid_d;
    logic              rspWrite_q, rspWrite_d;
    logic [DATA_W-1:0] rspRdata_q, rspRdata_d;
    logic              rspErr_q, rspErr_d;

    logic              fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [CMD_W-1:0]  fifoData;
    logic              headWrite;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headWdata;
    logic              rspSlotFree;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
`else
    logic [31:0] unusedTimeoutCfg;
    assign unusedTimeoutCfg = TIMEOUT_CYCLES;
`endif

    assign fifoPush = i_cmd_valid && !fifoFull;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (fifoPush),
        .i_data  ({i_cmd_write, i_cmd_addr, i_cmd_wdata}),
        .i_pop   (fifoPop),
        .o_data  (fifoData),
        .o_full  (fifoFull),
        .o_empty (fifoEmpty)
    );

    assign {headWrite, headAddr, headWdata} = fifoData;

    // A transfer may only start if its response cannot overwrite an unconsumed one.
    assign rspSlotFree = !rspValid_q || i_rsp_ready;

    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rspValid_d = rspValid_q && !i_rsp_ready;
        rspWrite_d = rspWrite_q;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        fifoPop    = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        tmoCnt_d   = tmoCnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifoEmpty && rspSlotFree) begin
                    fifoPop  = 1'b1;
                    state_d  = SETUP;
                    paddr_d  = headAddr;
                    pwrite_d = headWrite;
                    pwdata_d = headWrite ? headWdata : '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                tmoCnt_d = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b1;
                    rspWrite_d = pwrite_q;
                    rspRdata_d = pwrite_q ? '0 : PRDATA;
                    rspErr_d   = PSLVERR;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b1;
                    rspWrite_d = pwrite_q;
                    rspRdata_d = '0;
                    rspErr_d   = 1'b1;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rspValid_q <= 1'b0;
            rspWrite_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmoCnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rspValid_q <= rspValid_d;
            rspWrite_q <= rspWrite_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
`ifdef APB_MASTER_TIMEOUT_EN
            tmoCnt_q   <= tmoCnt_d;
`endif
        end
    end

    assign PSELx       = (state_q != IDLE);
    assign PENABLE     = (state_q == ACCESS);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign o_cmd_ready = !fifoFull;
    assign o_rsp_valid = rspValid_q;
    assign o_rsp_write = rspWrite_q;
    assign o_rsp_rdata = rspRdata_q;
    assign o_rsp_err   = rspErr_q;
    assign o_busy      = !fifoEmpty || (state_q != IDLE) || rspValid_q;

endmodule
